ct_rtu_iid_alloc: RTL and testbench

- Allocator and retirer of the 7-bit instruction IDs (IIDs) that all RTU age comparisons consume.
- IID format: bit 6 is the wrap flag, bits 5:0 are the ROB index.
- Hands up to 4 consecutive IIDs per cycle to IDU dispatch and reclaims up to 3 per cycle on ROB retire.
- Tracks free count, full and empty, and rewinds the allocation pointer on pipeline flush.

---
 rtl/ct_rtu_iid_alloc.sv | 98 +++++++++
 tb/tb_ct_rtu_iid_alloc.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ct_rtu_iid_alloc.sv
// IID allocator/retirer: a two-pointer ring over 7-bit IIDs (wrap bit + 6-bit ROB index)
// with registered free count, full/empty flags and a sticky retire-underflow error.
module ct_rtu_iid_alloc #(
    parameter int ENTRIES  = 64,
    parameter int ALLOC_W  = 4,
    parameter int RETIRE_W = 3
) (
    input  logic       forever_cpuclk,
    input  logic       cpurst,
    input  logic       idu_rtu_alloc_req,
    input  logic [2:0] idu_rtu_alloc_num,
    output logic       rtu_idu_alloc_gnt,
    output logic [6:0] rtu_idu_alloc_iid0,
    output logic [6:0] rtu_idu_alloc_iid1,
    output logic [6:0] rtu_idu_alloc_iid2,
    output logic [6:0] rtu_idu_alloc_iid3,
    input  logic [1:0] rob_rtu_retire_num,
    input  logic       rtu_yy_xx_flush,
    output logic [6:0] rtu_idu_free_cnt,
    output logic       rtu_idu_full,
    output logic       rtu_yy_xx_empty,
    output logic [6:0] rtu_oldest_iid,
    output logic       rtu_err_underflow
);

    localparam logic [6:0] FULL_CNT   = 7'(ENTRIES);
    localparam logic [6:0] ALLOC_MAX  = 7'(ALLOC_W);
    localparam logic [6:0] RETIRE_MAX = 7'(RETIRE_W);

    // The IID wrap bit only works if the ring is exactly 2^6 deep.
    if (ENTRIES != 64) begin : g_bad_entries
        $error("ct_rtu_iid_alloc: ENTRIES must be 64");
    end

    logic [6:0] alloc_ptr_q, alloc_ptr_d;
    logic [6:0] retire_ptr_q, retire_ptr_d;
    logic [6:0] free_cnt_q, free_cnt_d;
    logic       full_q, empty_q, err_q, err_d;

    logic [6:0] num_ext, rn_ext, occ, num_eff, rn_eff;
    logic       num_legal, retire_bad, retire_ok;

    always_comb begin
        // NOTE: every signal gets a value on every path so no latch is inferred.
        num_ext    = {4'b0, idu_rtu_alloc_num};
        rn_ext     = {5'b0, rob_rtu_retire_num};
        occ        = FULL_CNT - free_cnt_q;
        num_legal  = (num_ext != '0) && (num_ext <= ALLOC_MAX) && (num_ext <= free_cnt_q);
        rtu_idu_alloc_gnt = idu_rtu_alloc_req && !rtu_yy_xx_flush && !cpurst && num_legal;

        // Over-retire is rejected whole; it never partially advances the pointer.
        retire_bad = rn_ext > occ;
        retire_ok  = (rn_ext != '0) && !retire_bad && (rn_ext <= RETIRE_MAX);
        rn_eff     = retire_ok ? rn_ext : '0;
        num_eff    = rtu_idu_alloc_gnt ? num_ext : '0;

        retire_ptr_d = retire_ptr_q + rn_eff;
        err_d        = err_q | retire_bad;

        if (rtu_yy_xx_flush) begin
            alloc_ptr_d = retire_ptr_d;
            free_cnt_d  = FULL_CNT;
        end else begin
            alloc_ptr_d = alloc_ptr_q + num_eff;
            free_cnt_d  = free_cnt_q - num_eff + rn_eff;
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            alloc_ptr_q  <= '0;
            retire_ptr_q <= '0;
            free_cnt_q   <= FULL_CNT;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            alloc_ptr_q  <= alloc_ptr_d;
            retire_ptr_q <= retire_ptr_d;
            free_cnt_q   <= free_cnt_d;
            full_q       <= (free_cnt_d == '0);
            empty_q      <= (free_cnt_d == FULL_CNT);
            err_q        <= err_d;
        end
    end

    assign rtu_idu_alloc_iid0 = alloc_ptr_q;
    assign rtu_idu_alloc_iid1 = alloc_ptr_q + 7'd1;
    assign rtu_idu_alloc_iid2 = alloc_ptr_q + 7'd2;
    assign rtu_idu_alloc_iid3 = alloc_ptr_q + 7'd3;
    assign rtu_idu_free_cnt   = free_cnt_q;
    assign rtu_idu_full       = full_q;
    assign rtu_yy_xx_empty    = empty_q;
    assign rtu_oldest_iid     = retire_ptr_q;
    assign rtu_err_underflow  = err_q;

endmodule

// File: tb/tb_ct_rtu_iid_alloc.sv
// Scoreboard bench for ct_rtu_iid_alloc: a queue-of-IIDs reference model predicts each
// cycle's outputs; a negedge monitor pops and compares them.
module tb_ct_rtu_iid_alloc;

    logic       clk = 1'b0;
    logic       cpurst = 1'b1;
    logic       req = 1'b0;
    logic [2:0] num = 3'd0;
    logic [1:0] rn = 2'd0;
    logic       flush = 1'b0;
    logic       gnt, full, empty, err;
    logic [6:0] iid0, iid1, iid2, iid3, free_cnt, oldest;

    ct_rtu_iid_alloc dut (
        .forever_cpuclk     (clk),
        .cpurst             (cpurst),
        .idu_rtu_alloc_req  (req),
        .idu_rtu_alloc_num  (num),
        .rtu_idu_alloc_gnt  (gnt),
        .rtu_idu_alloc_iid0 (iid0),
        .rtu_idu_alloc_iid1 (iid1),
        .rtu_idu_alloc_iid2 (iid2),
        .rtu_idu_alloc_iid3 (iid3),
        .rob_rtu_retire_num (rn),
        .rtu_yy_xx_flush    (flush),
        .rtu_idu_free_cnt   (free_cnt),
        .rtu_idu_full       (full),
        .rtu_yy_xx_empty    (empty),
        .rtu_oldest_iid     (oldest),
        .rtu_err_underflow  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       gnt;
        logic [6:0] iid [4];
        logic [6:0] free_cnt;
        logic       full;
        logic       empty;
        logic [6:0] oldest;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: the ordered list of in-flight IIDs plus the next IID to hand out.
    int inflight[$];
    int next_iid = 0;
    bit err_m    = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    function automatic exp_t predict(input bit r, input int n, input bit fl, input bit in_rst);
        exp_t e;
        int free;
        free       = 64 - inflight.size();
        e.free_cnt = 7'(free);
        e.full     = (free == 0);
        e.empty    = (free == 64);
        e.oldest   = 7'((inflight.size() != 0) ? inflight[0] : next_iid);
        e.err      = err_m;
        e.gnt      = r && !fl && !in_rst && (n >= 1) && (n <= 4) && (n <= free);
        for (int k = 0; k < 4; k++) e.iid[k] = 7'((next_iid + k) % 128);
        return e;
    endfunction

    task automatic cycle(input bit r, input int n, input int rr, input bit fl);
        exp_t e;
        @(posedge clk);
        #1;
        cpurst = 1'b0;
        req    = r;
        num    = 3'(n);
        rn     = 2'(rr);
        flush  = fl;
        e = predict(r, n, fl, 1'b0);
        exp_q.push_back(e);
        if (rr > inflight.size()) err_m = 1'b1;
        else for (int k = 0; k < rr; k++) void'(inflight.pop_front());
        if (fl) begin
            if (inflight.size() != 0) next_iid = inflight[0];
            inflight.delete();
        end else if (e.gnt) begin
            for (int k = 0; k < n; k++) begin
                inflight.push_back(next_iid);
                next_iid = (next_iid + 1) % 128;
            end
        end
    endtask

    // Reset is raised mid-cycle with a live request to show it kills state and grant at once.
    task automatic do_reset();
        @(posedge clk);
        #1;
        cpurst = 1'b1;
        req    = 1'b1;
        num    = 3'd1;
        rn     = 2'd3;
        flush  = 1'b0;
        inflight.delete();
        next_iid = 0;
        err_m    = 1'b0;
        exp_q.push_back(predict(1'b1, 1, 1'b0, 1'b1));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("gnt", gnt, e.gnt);
                check("iid0", iid0, e.iid[0]);
                check("iid1", iid1, e.iid[1]);
                check("iid2", iid2, e.iid[2]);
                check("iid3", iid3, e.iid[3]);
                check("free_cnt", free_cnt, e.free_cnt);
                check("full", full, e.full);
                check("empty", empty, e.empty);
                check("oldest", oldest, e.oldest);
                check("err", err, e.err);
            end
        end
    end

    initial begin : stimulus
        int occ, n, rr;
        do_reset();
        // Fill: 16 x 4 then a refused 17th request.
        for (int i = 0; i < 16; i++) cycle(1, 4, 0, 0);
        cycle(1, 4, 0, 0);
        cycle(0, 0, 0, 0);
        // Drain 64: 21 x 3 then 1, leaving oldest at 0x40.
        for (int i = 0; i < 21; i++) cycle(0, 0, 3, 0);
        cycle(0, 0, 1, 0);
        cycle(1, 2, 0, 0);
        // Refill to full, then simultaneous grant/retire from full.
        for (int i = 0; i < 15; i++) cycle(1, 4, 0, 0);
        cycle(1, 2, 0, 0);
        cycle(1, 2, 3, 0);
        cycle(1, 3, 2, 0);
        cycle(0, 0, 0, 0);
        // Flush with occ = 10, oldest = 0x05, retire 2 and a request that must be refused.
        do_reset();
        cycle(1, 4, 0, 0);
        cycle(1, 4, 0, 0);
        cycle(1, 4, 0, 0);
        cycle(1, 3, 3, 0);
        cycle(0, 0, 2, 0);
        cycle(1, 1, 2, 1);
        cycle(0, 0, 0, 0);
        // Underflow: occ = 1 and retire 3, then legal traffic; err must stick.
        cycle(1, 1, 0, 0);
        cycle(0, 0, 3, 0);
        cycle(1, 4, 0, 0);
        cycle(0, 0, 2, 0);
        cycle(1, 5, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 7, 0, 0);
        // Random traffic with a reset dropped in the middle.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            occ = inflight.size();
            n   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 4);
            if ($urandom_range(0, 99) == 0) rr = 3;
            else rr = $urandom_range(0, (occ < 3) ? occ : 3);
            cycle($urandom_range(0, 3) != 0, n, rr, $urandom_range(0, 49) == 0);
        end
        cycle(0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
